mem_arbiter: RTL and testbench

Two-requester arbiter that shares one unified memory port between instruction fetch (the icache request path driven by PC) and data access (the load/store path from MEM). It sits between the core and the memory/cache model and keeps one transaction outstanding at a time. Data requests have priority over fetches; an optional starvation guard forces a fetch grant after repeated data grants. Fetch responses can be cancelled by a branch flush.

---
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates one shared memory port between fetch (ifu) and load/store (lsu) traffic, one transaction in flight.
// Build with MEM_ARB_FAIR_EN defined to add a starvation guard that forces a fetch grant after FAIR_LIMIT data grants.
module mem_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int FAIR_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid_i,
    input  logic [ADDR_W-1:0]   ifu_addr_i,
    input  logic                ifu_flush_i,
    output logic                ifu_req_ready_o,
    output logic                ifu_rsp_valid_o,
    output logic [31:0]         ifu_rdata_o,
    input  logic                lsu_req_valid_i,
    input  logic [ADDR_W-1:0]   lsu_addr_i,
    input  logic                lsu_wen_i,
    input  logic [DATA_W-1:0]   lsu_wdata_i,
    input  logic [DATA_W/8-1:0] lsu_wstrb_i,
    output logic                lsu_req_ready_o,
    output logic                lsu_rsp_valid_o,
    output logic [DATA_W-1:0]   lsu_rdata_o,
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic                mem_wen_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_wstrb_o,
    input  logic                mem_rsp_valid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} state_t;

    state_t state;
    logic   owner_ifu;
    logic   drop;
    logic   force_ifu;
    logic   lsu_grant;
    logic   ifu_grant;

`ifdef MEM_ARB_FAIR_EN
    localparam int CNT_W = $clog2(FAIR_LIMIT + 1);
    logic [CNT_W-1:0] starve_cnt;

    assign force_ifu = (starve_cnt == CNT_W'(FAIR_LIMIT)) && ifu_req_valid_i && !ifu_flush_i;

    // Counts data grants that overtook a waiting fetch; saturates until the fetch is served.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (ifu_grant) begin
            starve_cnt <= '0;
        end else if (lsu_grant && ifu_req_valid_i && (starve_cnt != CNT_W'(FAIR_LIMIT))) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end
`else
    assign force_ifu = 1'b0;
`endif

    // Gating with rst keeps both readies low while reset is held.
    assign lsu_grant = rst && (state == IDLE) && lsu_req_valid_i && !force_ifu;
    assign ifu_grant = rst && (state == IDLE) && ifu_req_valid_i && !ifu_flush_i && !lsu_grant;

    assign lsu_req_ready_o = lsu_grant;
    assign ifu_req_ready_o = ifu_grant;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            owner_ifu       <= 1'b0;
            drop            <= 1'b0;
            mem_req_valid_o <= 1'b0;
            mem_addr_o      <= '0;
            mem_wen_o       <= 1'b0;
            mem_wdata_o     <= '0;
            mem_wstrb_o     <= '0;
            ifu_rsp_valid_o <= 1'b0;
            ifu_rdata_o     <= '0;
            lsu_rsp_valid_o <= 1'b0;
            lsu_rdata_o     <= '0;
        end else begin
            ifu_rsp_valid_o <= 1'b0;
            lsu_rsp_valid_o <= 1'b0;
            if ((state != IDLE) && owner_ifu && ifu_flush_i) begin
                drop <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (lsu_grant) begin
                        owner_ifu       <= 1'b0;
                        mem_req_valid_o <= 1'b1;
                        mem_addr_o      <= lsu_addr_i;
                        mem_wen_o       <= lsu_wen_i;
                        mem_wdata_o     <= lsu_wdata_i;
                        mem_wstrb_o     <= lsu_wstrb_i;
                        state           <= REQ;
                    end else if (ifu_grant) begin
                        owner_ifu       <= 1'b1;
                        mem_req_valid_o <= 1'b1;
                        mem_addr_o      <= ifu_addr_i;
                        mem_wen_o       <= 1'b0;
                        mem_wdata_o     <= '0;
                        mem_wstrb_o     <= '0;
                        state           <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready_i) begin
                        mem_req_valid_o <= 1'b0;
                        state           <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (mem_rsp_valid_i) begin
                        state <= IDLE;
                        drop  <= 1'b0;
                        if (owner_ifu) begin
                            // A flush arriving with the response still cancels it.
                            ifu_rsp_valid_o <= !(drop || ifu_flush_i);
                            ifu_rdata_o     <= mem_rdata_i[31:0];
                        end else begin
                            lsu_rsp_valid_o <= 1'b1;
                            lsu_rdata_o     <= mem_wen_o ? '0 : mem_rdata_i;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: a reference model predicts grants, downstream commands and responses.
// Define MEM_ARB_FAIR_EN for both RTL and bench to exercise the fairness build.
module tb_mem_arbiter;
    localparam int ADDR_W     = 64;
    localparam int DATA_W     = 64;
    localparam int FAIR_LIMIT = 4;

    typedef struct {
        logic [63:0] addr;
        logic        wen;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ifu_req_valid_i = 1'b0, ifu_flush_i = 1'b0, ifu_req_ready_o, ifu_rsp_valid_o;
    logic [63:0] ifu_addr_i = '0;
    logic [31:0] ifu_rdata_o;
    logic        lsu_req_valid_i = 1'b0, lsu_wen_i = 1'b0, lsu_req_ready_o, lsu_rsp_valid_o;
    logic [63:0] lsu_addr_i = '0, lsu_wdata_i = '0, lsu_rdata_o;
    logic [7:0]  lsu_wstrb_i = '0, mem_wstrb_o;
    logic        mem_req_valid_o, mem_req_ready_i = 1'b0, mem_wen_o, mem_rsp_valid_i = 1'b0;
    logic [63:0] mem_addr_o, mem_wdata_o, mem_rdata_i = '0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FAIR_LIMIT(FAIR_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid_i(ifu_req_valid_i), .ifu_addr_i(ifu_addr_i), .ifu_flush_i(ifu_flush_i),
        .ifu_req_ready_o(ifu_req_ready_o), .ifu_rsp_valid_o(ifu_rsp_valid_o), .ifu_rdata_o(ifu_rdata_o),
        .lsu_req_valid_i(lsu_req_valid_i), .lsu_addr_i(lsu_addr_i), .lsu_wen_i(lsu_wen_i),
        .lsu_wdata_i(lsu_wdata_i), .lsu_wstrb_i(lsu_wstrb_i), .lsu_req_ready_o(lsu_req_ready_o),
        .lsu_rsp_valid_o(lsu_rsp_valid_o), .lsu_rdata_o(lsu_rdata_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i), .mem_addr_o(mem_addr_o),
        .mem_wen_o(mem_wen_o), .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
        .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rdata_i(mem_rdata_i)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Stimulus knobs (percentages) and shared handshake bookkeeping.
    int ifu_rate, lsu_rate, flush_rate, rdy_rate, stray_rate, dmax;
    bit mon_en = 1'b0;
    bit ifu_acc = 1'b0, lsu_acc = 1'b0;
    bit mem_pend = 1'b0, rsp_real = 1'b0;
    logic [63:0] mem_pend_addr = '0;
    int mem_delay = 0;

    // Reference model state.
    cmd_t        cmd_q[$];
    logic [63:0] ifu_q[$];
    logic [63:0] lsu_q[$];
    bit  m_idle = 1'b1, m_req = 1'b0, m_own_ifu = 1'b0, m_drop = 1'b0, m_wen = 1'b0;
    bit  ifu_due = 1'b0, lsu_due = 1'b0;
    logic [63:0] m_addr = '0;
    int  m_starve = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] mem_val(input logic [63:0] a);
        return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    always @(negedge clk) begin : monitor
        cmd_t        c;
        logic [63:0] e;
        bit          frc, exp_l, exp_i, go_idle;
        if (mon_en) begin
            go_idle = 1'b0;
            chk("ifu_rsp_vld", ifu_rsp_valid_o, ifu_due);
            if (ifu_due) begin
                e = ifu_q.pop_front();
                if (ifu_rsp_valid_o) chk("ifu_rdata", {32'h0, ifu_rdata_o}, e);
            end
            chk("lsu_rsp_vld", lsu_rsp_valid_o, lsu_due);
            if (lsu_due) begin
                e = lsu_q.pop_front();
                if (lsu_rsp_valid_o) chk("lsu_rdata", lsu_rdata_o, e);
            end
            ifu_due = 1'b0;
            lsu_due = 1'b0;

            chk("mem_req_vld", mem_req_valid_o, m_req);
            if (m_req && cmd_q.size() > 0) begin
                c = cmd_q[0];
                chk("mem_addr", mem_addr_o, c.addr);
                chk("mem_wen", mem_wen_o, c.wen);
                chk("mem_wdata", mem_wdata_o, c.wdata);
                chk("mem_wstrb", mem_wstrb_o, c.wstrb);
                if (mem_req_ready_i) begin
                    void'(cmd_q.pop_front());
                    m_req         = 1'b0;
                    mem_pend      = 1'b1;
                    mem_pend_addr = c.addr;
                    mem_delay     = $urandom_range(dmax);
                end
            end

            if (!m_idle && m_own_ifu && ifu_flush_i) m_drop = 1'b1;
            if (mem_rsp_valid_i && rsp_real) begin
                if (!m_own_ifu) begin
                    lsu_q.push_back(m_wen ? 64'h0 : mem_val(m_addr));
                    lsu_due = 1'b1;
                end else if (!m_drop) begin
                    ifu_q.push_back({32'h0, mem_val(m_addr)[31:0]});
                    ifu_due = 1'b1;
                end
                go_idle = 1'b1;
            end

`ifdef MEM_ARB_FAIR_EN
            frc = (m_starve >= FAIR_LIMIT) && ifu_req_valid_i && !ifu_flush_i;
`else
            frc = 1'b0;
`endif
            exp_l = m_idle && lsu_req_valid_i && !frc;
            exp_i = m_idle && ifu_req_valid_i && !ifu_flush_i && !exp_l;
            chk("lsu_ready", lsu_req_ready_o, exp_l);
            chk("ifu_ready", ifu_req_ready_o, exp_i);
            if (lsu_req_ready_o) begin
                cmd_q.push_back('{addr: lsu_addr_i, wen: lsu_wen_i, wdata: lsu_wdata_i, wstrb: lsu_wstrb_i});
                m_own_ifu = 1'b0;
                m_addr    = lsu_addr_i;
                m_wen     = lsu_wen_i;
                if (ifu_req_valid_i && m_starve < FAIR_LIMIT) m_starve++;
                lsu_acc = 1'b1;
            end else if (ifu_req_ready_o) begin
                cmd_q.push_back('{addr: ifu_addr_i, wen: 1'b0, wdata: 64'h0, wstrb: 8'h0});
                m_own_ifu = 1'b1;
                m_addr    = ifu_addr_i;
                m_wen     = 1'b0;
                m_drop    = 1'b0;
                m_starve  = 0;
                ifu_acc   = 1'b1;
            end
            if (lsu_req_ready_o || ifu_req_ready_o) begin
                m_idle = 1'b0;
                m_req  = 1'b1;
            end
            if (go_idle) m_idle = 1'b1;
        end
    end

    task automatic drive_cycle();
        @(posedge clk);
        #1;
        if (ifu_acc) begin ifu_req_valid_i = 1'b0; ifu_acc = 1'b0; end
        if (lsu_acc) begin lsu_req_valid_i = 1'b0; lsu_acc = 1'b0; end
        if (!ifu_req_valid_i && $urandom_range(99) < ifu_rate) begin
            ifu_req_valid_i = 1'b1;
            ifu_addr_i      = {$urandom, $urandom} & ~64'h3;
        end
        if (!lsu_req_valid_i && $urandom_range(99) < lsu_rate) begin
            lsu_req_valid_i = 1'b1;
            lsu_addr_i      = {$urandom, $urandom} & ~64'h7;
            lsu_wen_i       = $urandom_range(1) == 1;
            lsu_wdata_i     = {$urandom, $urandom};
            lsu_wstrb_i     = 8'($urandom);
        end
        ifu_flush_i     = $urandom_range(99) < flush_rate;
        mem_req_ready_i = $urandom_range(99) < rdy_rate;
        mem_rsp_valid_i = 1'b0;
        rsp_real        = 1'b0;
        mem_rdata_i     = {$urandom, $urandom};
        if (mem_pend) begin
            if (mem_delay == 0) begin
                mem_rsp_valid_i = 1'b1;
                rsp_real        = 1'b1;
                mem_rdata_i     = mem_val(mem_pend_addr);
                mem_pend        = 1'b0;
            end else begin
                mem_delay--;
            end
        end else if ($urandom_range(99) < stray_rate) begin
            mem_rsp_valid_i = 1'b1;
        end
    endtask

    task automatic run_phase(input int ir, input int lr, input int fr, input int rr,
                             input int sr, input int dm, input int cycles);
        ifu_rate = ir; lsu_rate = lr; flush_rate = fr; rdy_rate = rr; stray_rate = sr; dmax = dm;
        for (int i = 0; i < cycles; i++) drive_cycle();
    endtask

    initial begin
        int waited;
        ifu_req_valid_i = 1'b1;
        lsu_req_valid_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ifu_ready", ifu_req_ready_o, 0);
        chk("rst_lsu_ready", lsu_req_ready_o, 0);
        chk("rst_mem_vld", mem_req_valid_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_ifu_rsp", ifu_rsp_valid_o, 0);
        chk("rst_lsu_rsp", lsu_rsp_valid_o, 0);
        ifu_req_valid_i = 1'b0;
        lsu_req_valid_i = 1'b0;
        rst    = 1'b1;
        mon_en = 1'b1;

        run_phase(40, 40, 10, 70, 5, 3, 1500);
        run_phase(100, 100, 0, 100, 0, 0, 400);
        run_phase(30, 50, 5, 20, 10, 2, 1500);

        ifu_rate = 0; lsu_rate = 0; flush_rate = 0; rdy_rate = 100; stray_rate = 0;
        waited = 0;
        while (waited < 400 && (ifu_req_valid_i || lsu_req_valid_i || !m_idle || mem_pend)) begin
            drive_cycle();
            waited++;
        end
        repeat (3) drive_cycle();
        chk("drain_idle", {63'h0, m_idle}, 1);
        chk("drain_cmd_q", cmd_q.size(), 0);
        chk("drain_ifu_q", ifu_q.size(), 0);
        chk("drain_lsu_q", lsu_q.size(), 0);

        mon_en = 1'b0;
        @(posedge clk);
        #1;
        lsu_req_valid_i = 1'b1;
        lsu_addr_i      = 64'h40;
        lsu_wen_i       = 1'b0;
        mem_req_ready_i = 1'b0;
        @(negedge clk);
        chk("rstreq_grant", lsu_req_ready_o, 1);
        @(posedge clk);
        #1;
        lsu_req_valid_i = 1'b0;
        @(negedge clk);
        chk("rstreq_mem_vld", mem_req_valid_o, 1);
        chk("rstreq_mem_addr", mem_addr_o, 64'h40);
        ifu_req_valid_i = 1'b1;
        lsu_req_valid_i = 1'b1;
        rst = 1'b0;
        #1;
        chk("rstmid_mem_vld", mem_req_valid_o, 0);
        chk("rstmid_mem_addr", mem_addr_o, 0);
        chk("rstmid_ifu_ready", ifu_req_ready_o, 0);
        chk("rstmid_lsu_ready", lsu_req_ready_o, 0);
        @(posedge clk);
        #1;
        ifu_req_valid_i = 1'b0;
        lsu_req_valid_i = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        mem_rsp_valid_i = 1'b1;
        mem_rdata_i     = 64'h1122_3344_5566_7788;
        @(posedge clk);
        #1;
        mem_rsp_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("late_ifu_rsp", ifu_rsp_valid_o, 0);
            chk("late_lsu_rsp", lsu_rsp_valid_o, 0);
            chk("late_mem_vld", mem_req_valid_o, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
